// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the iterative multiply/divide unit.
package muldiv_pkg;
    localparam int WIDTH = 16;
    localparam logic [WIDTH-1:0] DIV0_QUO = 16'hFFFF;

    typedef enum logic [1:0] {
        OP_MUL_LO = 2'b00,
        OP_MUL_HI = 2'b01,
        OP_DIV_Q  = 2'b10,
        OP_DIV_R  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_e;
endpackage

// File: rtl/muldiv_iter_step.sv
// One combinational iteration: shift-add multiply step or restoring divide step.
module muldiv_iter_step #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input  logic               is_div,
    input  logic [2*WIDTH-1:0] acc_in,
    input  logic [WIDTH-1:0]   rem_in,
    input  logic [WIDTH-1:0]   opa,
    input  logic [WIDTH-1:0]   opb,
    input  logic [CNT_W-1:0]   cnt,
    output logic [2*WIDTH-1:0] acc_out,
    output logic [WIDTH-1:0]   rem_out,
    output logic               quo_bit
);
    logic [WIDTH:0] rem_sh;

    // Stored remainder is always below the divisor, so the shifted value fits in
    // WIDTH+1 bits and the modulo-WIDTH subtract is exact whenever it is taken.
    always_comb begin
        rem_sh  = {rem_in, acc_in[WIDTH-1]};
        quo_bit = 1'b0;
        acc_out = acc_in;
        rem_out = rem_in;
        if (is_div) begin
            quo_bit = (rem_sh >= {1'b0, opb});
            rem_out = quo_bit ? (rem_sh[WIDTH-1:0] - opb) : rem_sh[WIDTH-1:0];
            acc_out = {acc_in[2*WIDTH-1:WIDTH], acc_in[WIDTH-2:0], quo_bit};
        end else if (opb[cnt]) begin
            acc_out = acc_in + ({{WIDTH{1'b0}}, opa} << cnt);
        end
    end
endmodule

// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply/divide unit feeding the register-file write port.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int CNT_W  = 4,
    parameter int REG_AW = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [WIDTH-1:0]  operand_a,
    input  logic [WIDTH-1:0]  operand_b,
    input  logic [REG_AW-1:0] dest_reg,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  result,
    output logic [REG_AW-1:0] result_reg,
    output logic              div_by_zero
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e              state, state_nxt;
    op_e                 op_q;
    logic [WIDTH-1:0]    a_q, b_q;
    logic [REG_AW-1:0]   dest_q;
    logic [CNT_W-1:0]    cnt;
    logic [2*WIDTH-1:0]  acc, acc_nxt;
    logic [WIDTH-1:0]    rem, rem_nxt;
    logic                quo_bit;
    logic                is_div, b_zero;
    logic [WIDTH-1:0]    res_sel;

    assign is_div = (op_q == OP_DIV_Q) || (op_q == OP_DIV_R);
    assign b_zero = (b_q == '0);
    assign busy   = (state != S_IDLE);
    assign done   = (state == S_DONE);

    muldiv_iter_step #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_step (
        .is_div  (is_div),
        .acc_in  (acc),
        .rem_in  (rem),
        .opa     (a_q),
        .opb     (b_q),
        .cnt     (cnt),
        .acc_out (acc_nxt),
        .rem_out (rem_nxt),
        .quo_bit (quo_bit)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (cnt == CNT_LAST) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Result is captured from the final iteration's step output so it is valid in DONE.
    always_comb begin
        res_sel = acc_nxt[WIDTH-1:0];
        case (op_q)
            OP_MUL_LO: res_sel = acc_nxt[WIDTH-1:0];
            OP_MUL_HI: res_sel = acc_nxt[2*WIDTH-1:WIDTH];
            OP_DIV_Q:  res_sel = b_zero ? DIV0_QUO : acc_nxt[WIDTH-1:0];
            OP_DIV_R:  res_sel = b_zero ? a_q : rem_nxt;
            default:   res_sel = acc_nxt[WIDTH-1:0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q        <= OP_MUL_LO;
            a_q         <= '0;
            b_q         <= '0;
            dest_q      <= '0;
            cnt         <= '0;
            acc         <= '0;
            rem         <= '0;
            result      <= '0;
            result_reg  <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    op_q   <= op_e'(op);
                    a_q    <= operand_a;
                    b_q    <= operand_b;
                    dest_q <= dest_reg;
                    cnt    <= '0;
                    rem    <= '0;
                    // Divide keeps the dividend in the low half; it shifts out as the quotient shifts in.
                    acc    <= op[1] ? {{WIDTH{1'b0}}, operand_a} : '0;
                end
                S_RUN: begin
                    acc <= acc_nxt;
                    rem <= rem_nxt;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        result      <= res_sel;
                        result_reg  <= dest_q;
                        div_by_zero <= is_div && b_zero;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: latency, results, div-by-zero, busy-start, reset abort.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [15:0] a = '0, b = '0;
    logic [3:0]  dest = '0;
    logic        busy, done, div_by_zero;
    logic [15:0] result;
    logic [3:0]  result_reg;
    int          n_tests = 0, n_fail = 0;

    muldiv_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op          (op),
        .operand_a   (a),
        .operand_b   (b),
        .dest_reg    (dest),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .result_reg  (result_reg),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; that cycle is cycle 0. Observes cycles 1..19.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [15:0] oa,
                          input logic [15:0] ob, input logic [3:0] d,
                          input logic [15:0] exp_res, input logic exp_dz, input logic meddle);
        int nb = 0, nd = 0, dc = 0;
        logic [15:0] r = '0;
        logic [3:0]  rr = '0;
        logic        dz = 1'b0;
        op = o; a = oa; b = ob; dest = d; start = 1'b1;
        for (int k = 1; k <= 19; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (busy) nb++;
            if (done) begin nd++; dc = k; r = result; rr = result_reg; dz = div_by_zero; end
            if (meddle) begin
                if (k == 5) begin start = 1'b1; op = ~o; a = 16'h0F0F; b = 16'h0003; dest = ~d; end
                if (k == 6) start = 1'b0;
                if (k >= 6 && k < 14) begin a = a + 16'h1111; b = b ^ 16'h00FF; end
            end
        end
        chk({tag, ".busy_cycles"}, 32'(nb), 32'd17);
        chk({tag, ".done_count"}, 32'(nd), 32'd1);
        chk({tag, ".done_cycle"}, 32'(dc), 32'd17);
        chk({tag, ".result"}, 32'(r), 32'(exp_res));
        chk({tag, ".result_reg"}, 32'(rr), 32'(d));
        chk({tag, ".div_by_zero"}, 32'(dz), 32'(exp_dz));
        chk({tag, ".result_held"}, 32'(result), 32'(exp_res));
    endtask

    initial begin
        int nd;
        repeat (3) @(negedge clk);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.result", 32'(result), 32'd0);
        chk("rst.result_reg", 32'(result_reg), 32'd0);
        chk("rst.dz", 32'(div_by_zero), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("mul_lo_3x5",   2'b00, 16'd3,    16'd5,    4'd2, 16'h000F, 1'b0, 1'b0);
        run_op("mul_hi_ffff",  2'b01, 16'hFFFF, 16'hFFFF, 4'd3, 16'hFFFE, 1'b0, 1'b0);
        run_op("mul_lo_ffff",  2'b00, 16'hFFFF, 16'hFFFF, 4'd4, 16'h0001, 1'b0, 1'b0);
        run_op("div_q_100_7",  2'b10, 16'd100,  16'd7,    4'd5, 16'h000E, 1'b0, 1'b0);
        run_op("div_r_100_7",  2'b11, 16'd100,  16'd7,    4'd6, 16'h0002, 1'b0, 1'b0);
        run_op("div_q_5_9",    2'b10, 16'd5,    16'd9,    4'd7, 16'h0000, 1'b0, 1'b0);
        run_op("div_q_by0",    2'b10, 16'h1234, 16'h0000, 4'd8, 16'hFFFF, 1'b1, 1'b0);
        run_op("div_r_by0",    2'b11, 16'h1234, 16'h0000, 4'd9, 16'h1234, 1'b1, 1'b0);
        run_op("mul_clr_dz",   2'b00, 16'd3,    16'd5,    4'd1, 16'h000F, 1'b0, 1'b0);
        run_op("busy_ignore",  2'b00, 16'h0123, 16'h0010, 4'hA, 16'h1230, 1'b0, 1'b1);

        // Reset during RUN aborts with no done pulse; outputs return to reset values.
        nd = 0;
        op = 2'b00; a = 16'd3; b = 16'd5; dest = 4'd2; start = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (done) nd++;
            if (k == 8) rst_n = 1'b0;
            if (k == 9) begin
                chk("abort.busy", 32'(busy), 32'd0);
                chk("abort.result", 32'(result), 32'd0);
                chk("abort.result_reg", 32'(result_reg), 32'd0);
                rst_n = 1'b1;
            end
        end
        chk("abort.no_done", 32'(nd), 32'd0);
        run_op("after_abort",  2'b11, 16'd100,  16'd7,    4'd9, 16'h0002, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
